// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem requests, 2-entry return FIFO,
// and redirect flushing of buffered and in-flight fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  output logic        oIMemReq,
  output logic [31:0] oIMemAddr,
  input  logic        iIMemGnt,
  input  logic        iIMemRValid,
  input  logic [31:0] iIMemRData,
  output logic        oValid,
  input  logic        iDecReady,
  output logic [31:0] oInstr,
  output logic [31:0] oInstrPC,
  output logic [6:0]  oOpcode,
  output logic        oMisaligned
);

  typedef enum logic {S_REQ, S_WAIT} stateT;

  stateT       state;
  logic [31:0] pc, inflightPc;
  logic [31:0] bufInstr [2];
  logic [31:0] bufPc    [2];
  logic        head, tail, drop;
  logic [1:0]  count;
  logic        issue, push, pop;

  assign oIMemReq  = (state == S_REQ) && (count != 2'd2);
  assign oIMemAddr = pc;
  assign oValid    = (count != 2'd0);
  assign oInstr    = oValid ? bufInstr[head] : NOP_INSTR;
  assign oInstrPC  = oValid ? bufPc[head]    : pc;
  assign oOpcode   = oInstr[6:0];

  assign issue = oIMemReq && iIMemGnt;
  assign push  = (state == S_WAIT) && iIMemRValid && !drop && !iRedirect;
  assign pop   = oValid && iDecReady && !iRedirect;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      inflightPc  <= RESET_PC;
      count       <= 2'd0;
      head        <= 1'b0;
      tail        <= 1'b0;
      drop        <= 1'b0;
      oMisaligned <= 1'b0;
    end else begin
      case (state)
        S_REQ: if (issue) begin
          inflightPc <= pc;
          state      <= S_WAIT;
          drop       <= iRedirect;   // request left with the stale PC
        end
        S_WAIT: if (iIMemRValid) begin
          state <= S_REQ;
          drop  <= 1'b0;
          if (push) pc <= inflightPc + 32'd4;
        end
        default: state <= S_REQ;
      endcase

      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      // Redirect overrides the push/pop bookkeeping above.
      if (iRedirect) begin
        count <= 2'd0;
        head  <= 1'b0;
        tail  <= 1'b0;
        pc    <= {iRedirectPC[31:2], 2'b00};
        if (iRedirectPC[1:0] != 2'b00) oMisaligned <= 1'b1;
        if (state == S_WAIT && !iIMemRValid) drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) begin
      bufInstr[tail] <= iIMemRData;
      bufPc[tail]    <= inflightPc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory responder, in-order expectation
// queue popped by a monitor whenever decode consumes an instruction.
module tb_fetch_unit;

  logic        iCLK, iRST, iRedirect, iIMemGnt, iIMemRValid, iDecReady;
  logic [31:0] iRedirectPC, iIMemRData, oIMemAddr, oInstr, oInstrPC;
  logic        oIMemReq, oValid, oMisaligned;
  logic [6:0]  oOpcode;

  fetch_unit dut (
    .iCLK(iCLK), .iRST(iRST), .iRedirect(iRedirect), .iRedirectPC(iRedirectPC),
    .oIMemReq(oIMemReq), .oIMemAddr(oIMemAddr), .iIMemGnt(iIMemGnt),
    .iIMemRValid(iIMemRValid), .iIMemRData(iIMemRData), .oValid(oValid),
    .iDecReady(iDecReady), .oInstr(oInstr), .oInstrPC(oInstrPC),
    .oOpcode(oOpcode), .oMisaligned(oMisaligned)
  );

  typedef struct { logic [31:0] instr; logic [31:0] pc; } expT;
  expT expQ[$];

  int nChecks = 0, nFail = 0;
  int grantsIssued = 0, grantsUsed = 0;
  logic hold = 1'b0, pending = 1'b0;
  logic [31:0] pendAddr = 32'h0;

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h0050_0093;
      32'h0040_0004: return 32'h00A0_0113;
      32'h0040_0008: return 32'h0010_0193;
      32'h0040_000C: return 32'h0020_0213;
      32'h0040_0100: return 32'h0030_0293;
      32'h0040_0104: return 32'h0040_0313;
      32'h0040_0108: return 32'h0060_0413;
      32'h0040_0200: return 32'h0050_0393;
      32'hFFFF_FFFC: return 32'h0000_006F;
      default:       return 32'hBAD0_0013;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: grants while budget remains, answers one cycle later unless held.
  always @(negedge iCLK) begin
    if (iRST) begin
      pending     = 1'b0;
      iIMemRValid = 1'b0;
      iIMemGnt    = 1'b0;
    end else begin
      if (pending && !hold) begin
        iIMemRValid = 1'b1;
        iIMemRData  = mem(pendAddr);
        pending     = 1'b0;
      end else begin
        iIMemRValid = 1'b0;
        iIMemRData  = 32'h0;
      end
      iIMemGnt = (grantsUsed < grantsIssued);
      if (oIMemReq && iIMemGnt) begin
        pending  = 1'b1;
        pendAddr = oIMemAddr;
        grantsUsed++;
      end
    end
  end

  // Monitor: every consumed instruction must match the head expectation.
  always @(negedge iCLK) begin
    if (!iRST && oValid && iDecReady && !iRedirect) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("FAIL unexpected_instr: got %h @ %h expected none", oInstr, oInstrPC);
      end else begin
        expT e;
        e = expQ.pop_front();
        check("instr", oInstr, e.instr);
        check("instrPC", oInstrPC, e.pc);
        check("opcode", {25'h0, oOpcode}, {25'h0, e.instr[6:0]});
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    expT e;
    e.instr = mem(a);
    e.pc    = a;
    expQ.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || grantsUsed != grantsIssued || pending || iIMemRValid) && n < 40) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, n, (n < 40) ? n : 0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    grantsIssued = grantsUsed;
    tick();
    tick();
    iRST = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    iRedirect   = 1'b1;
    iRedirectPC = t;
    tick();
    iRedirect   = 1'b0;
  endtask

  initial begin
    iRST = 1'b1; iRedirect = 1'b0; iRedirectPC = 32'h0; iDecReady = 1'b0;
    iIMemGnt = 1'b0; iIMemRValid = 1'b0; iIMemRData = 32'h0;
    tick();
    do_reset();
    check("rst_valid", {31'h0, oValid}, 32'h0);
    check("rst_instr", oInstr, 32'h0000_0013);
    check("rst_opcode", {25'h0, oOpcode}, 32'h13);
    check("rst_instrPC", oInstrPC, 32'h0040_0000);
    check("rst_req", {31'h0, oIMemReq}, 32'h1);
    check("rst_addr", oIMemAddr, 32'h0040_0000);
    check("rst_misaligned", {31'h0, oMisaligned}, 32'h0);

    // 1: two sequential fetches, decode always ready; fixed 2-cycle latency
    iDecReady = 1'b1;
    expect_fetch(32'h0040_0000);
    expect_fetch(32'h0040_0004);
    grantsIssued += 2;
    tick(); tick();
    check("t1_latency_valid", {31'h0, oValid}, 32'h1);
    check("t1_latency_pc", oInstrPC, 32'h0040_0000);
    drain("t1");

    // 2: decode stalled -> FIFO fills, request drops, then resumes at +8
    do_reset();
    iDecReady = 1'b0;
    expect_fetch(32'h0040_0000);
    expect_fetch(32'h0040_0004);
    grantsIssued += 3;
    repeat (8) tick();
    check("t2_full_valid", {31'h0, oValid}, 32'h1);
    check("t2_full_req", {31'h0, oIMemReq}, 32'h0);
    check("t2_head_pc", oInstrPC, 32'h0040_0000);
    check("t2_stall_addr", oIMemAddr, 32'h0040_0008);
    expect_fetch(32'h0040_0008);
    iDecReady = 1'b1;
    drain("t2");

    // 3: redirect while waiting on 0x0040000C -> response dropped
    hold = 1'b1;
    grantsIssued += 1;
    tick();
    check("t3_wait_req", {31'h0, oIMemReq}, 32'h0);
    redirect(32'h0040_0100);
    check("t3_flush_valid", {31'h0, oValid}, 32'h0);
    check("t3_flush_instr", oInstr, 32'h0000_0013);
    hold = 1'b0;
    tick();
    check("t3_req", {31'h0, oIMemReq}, 32'h1);
    check("t3_addr", oIMemAddr, 32'h0040_0100);
    expect_fetch(32'h0040_0100);
    grantsIssued += 1;
    drain("t3");

    // 4: redirect coinciding with rvalid and a pop at count=1
    iDecReady = 1'b0;
    grantsIssued += 1;
    for (int i = 0; i < 10 && !oValid; i++) tick();
    check("t4_one_valid", {31'h0, oValid}, 32'h1);
    hold = 1'b1;
    grantsIssued += 1;
    tick();
    hold = 1'b0;
    iDecReady = 1'b1;
    redirect(32'h0040_0200);
    check("t4_valid", {31'h0, oValid}, 32'h0);
    check("t4_addr", oIMemAddr, 32'h0040_0200);
    check("t4_req", {31'h0, oIMemReq}, 32'h1);
    expect_fetch(32'h0040_0200);
    grantsIssued += 1;
    drain("t4");

    // 5: misaligned target -> sticky flag, aligned address, reset clears
    redirect(32'h0040_0102);
    check("t5_misaligned", {31'h0, oMisaligned}, 32'h1);
    check("t5_addr", oIMemAddr, 32'h0040_0100);
    tick();
    check("t5_sticky", {31'h0, oMisaligned}, 32'h1);
    do_reset();
    check("t5_rst_misaligned", {31'h0, oMisaligned}, 32'h0);
    check("t5_rst_addr", oIMemAddr, 32'h0040_0000);

    // 6: PC wraps from top of address space
    redirect(32'hFFFF_FFFC);
    check("t6_addr", oIMemAddr, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC);
    grantsIssued += 1;
    drain("t6");
    check("t6_wrap_addr", oIMemAddr, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
